// File: rtl/id_pattern_sequencer.sv
// LED strip ID pattern sequencer: each LED shows one bit of its own address,
// stepping through every bit (optionally with a complement pass) manually or automatically.
module id_pattern_sequencer #(
    parameter int unsigned NUM_LEDS          = 50,
    parameter int unsigned LED_ADDRESS_WIDTH = 6,
    parameter int unsigned SETTLE_FRAMES     = 2,
    parameter int unsigned HOLD_FRAMES       = 4,
    parameter int unsigned COMPLEMENT_PASS   = 1,
    parameter logic [23:0] ZERO_RGB          = 24'hFF0000,
    parameter logic [23:0] ONE_RGB           = 24'h0000FF,
    parameter logic [23:0] OFF_RGB           = 24'h000000,
    localparam int unsigned BIT_W = (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         auto_mode,
    input  logic                         increment_bit,
    input  logic                         decrement_bit,
    input  logic [LED_ADDRESS_WIDTH-1:0] led_request,
    input  logic                         request_valid,
    output logic [7:0]                   red_out,
    output logic [7:0]                   green_out,
    output logic [7:0]                   blue_out,
    output logic                         color_valid,
    output logic                         displayed_frame_valid,
    output logic [BIT_W-1:0]             address_bit_num,
    output logic                         inverted_phase,
    output logic                         sweep_done
);

    localparam int unsigned CP        = (COMPLEMENT_PASS != 0) ? 1 : 0;
    localparam int unsigned NUM_STEPS = LED_ADDRESS_WIDTH << CP;
    localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int unsigned LAST_STEP = NUM_STEPS - 1;
    localparam int unsigned SETTLE_W  = $clog2(SETTLE_FRAMES + 1);
    localparam int unsigned HOLD_W    = $clog2(HOLD_FRAMES + 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HOLD   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                inc_prev_q, dec_prev_q;
    logic [23:0]         rgb_q, rgb_d;
    logic                color_valid_q, color_valid_d;
    logic                dfv_q, dfv_d;
    logic                sweep_q, sweep_d;

    logic                inc_edge, dec_edge, any_edge, manual_step, fs, auto_adv, shown_bit;
    logic [STEP_W-1:0]   step_up, step_dn;

    // Event decode; any button edge masks the frame start so it is not counted
    assign inc_edge    = increment_bit & ~inc_prev_q;
    assign dec_edge    = decrement_bit & ~dec_prev_q;
    assign any_edge    = inc_edge | dec_edge;
    assign manual_step = inc_edge ^ dec_edge;
    assign fs          = request_valid && (led_request == '0) && !any_edge;
    assign step_up     = (step_q == STEP_W'(LAST_STEP)) ? '0 : step_q + STEP_W'(1);
    assign step_dn     = (step_q == '0) ? STEP_W'(LAST_STEP) : step_q - STEP_W'(1);
    assign auto_adv    = (state_q == ST_HOLD) && fs && auto_mode
                         && (hold_q >= HOLD_W'(HOLD_FRAMES - 1));

    assign address_bit_num = BIT_W'(step_q >> CP);
    assign inverted_phase  = (CP == 1) && step_q[0];
    assign shown_bit       = led_request[address_bit_num] ^ inverted_phase;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SETTLE;
            step_q        <= '0;
            settle_q      <= '0;
            hold_q        <= '0;
            inc_prev_q    <= increment_bit;
            dec_prev_q    <= decrement_bit;
            rgb_q         <= '0;
            color_valid_q <= 1'b0;
            dfv_q         <= 1'b0;
            sweep_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            settle_q      <= settle_d;
            hold_q        <= hold_d;
            inc_prev_q    <= increment_bit;
            dec_prev_q    <= decrement_bit;
            rgb_q         <= rgb_d;
            color_valid_q <= color_valid_d;
            dfv_q         <= dfv_d;
            sweep_q       <= sweep_d;
        end
    end

    // Next state, step and frame counters
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        settle_d = settle_q;
        hold_d   = hold_q;
        if (manual_step) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            hold_d   = '0;
            step_d   = inc_edge ? step_up : step_dn;
        end else if (fs) begin
            unique case (state_q)
                ST_SETTLE: begin
                    if (settle_q >= SETTLE_W'(SETTLE_FRAMES - 1)) begin
                        state_d  = ST_HOLD;
                        settle_d = SETTLE_W'(SETTLE_FRAMES);
                        hold_d   = '0;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (auto_adv) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                        hold_d   = '0;
                        step_d   = step_up;
                    end else if (hold_q != HOLD_W'(HOLD_FRAMES)) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: state_d = ST_SETTLE;
            endcase
        end
    end

    // Registered outputs: colour lookup, hold flag, sweep pulse
    always_comb begin
        rgb_d         = rgb_q;
        color_valid_d = request_valid;
        dfv_d         = (state_d == ST_HOLD);
        sweep_d       = auto_adv && (step_q == STEP_W'(LAST_STEP));
        if (request_valid) begin
            if (32'(led_request) >= NUM_LEDS) begin
                rgb_d = OFF_RGB;
            end else begin
                rgb_d = shown_bit ? ONE_RGB : ZERO_RGB;
            end
        end
    end

    assign red_out               = rgb_q[23:16];
    assign green_out             = rgb_q[15:8];
    assign blue_out              = rgb_q[7:0];
    assign color_valid           = color_valid_q;
    assign displayed_frame_valid = dfv_q;
    assign sweep_done            = sweep_q;

endmodule

// File: tb/tb_id_pattern_sequencer.sv
// Directed bench for id_pattern_sequencer: colour vector table plus hand-written
// sequences for settle/hold, wrapping, simultaneous events, auto sweep and reset.
module tb_id_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       auto_mode;
    logic       increment_bit;
    logic       decrement_bit;
    logic [5:0] led_request;
    logic       request_valid;
    logic [7:0] red_out, green_out, blue_out;
    logic       color_valid;
    logic       displayed_frame_valid;
    logic [2:0] address_bit_num;
    logic       inverted_phase;
    logic       sweep_done;

    id_pattern_sequencer dut (
        .clk                   (clk),
        .rst                   (rst),
        .auto_mode             (auto_mode),
        .increment_bit         (increment_bit),
        .decrement_bit         (decrement_bit),
        .led_request           (led_request),
        .request_valid         (request_valid),
        .red_out               (red_out),
        .green_out             (green_out),
        .blue_out              (blue_out),
        .color_valid           (color_valid),
        .displayed_frame_valid (displayed_frame_valid),
        .address_bit_num       (address_bit_num),
        .inverted_phase        (inverted_phase),
        .sweep_done            (sweep_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          step;
        logic [5:0]  addr;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [5:0] a);
        led_request   = a;
        request_valid = 1'b1;
        tick();
        request_valid = 1'b0;
    endtask

    task automatic pulse_inc();
        increment_bit = 1'b1;
        tick();
        increment_bit = 1'b0;
        tick();
    endtask

    task automatic pulse_dec();
        decrement_bit = 1'b1;
        tick();
        decrement_bit = 1'b0;
        tick();
    endtask

    task automatic check_step(input string name, input int s);
        chk({name, "_bit"}, 32'(address_bit_num), 32'(s >> 1));
        chk({name, "_phase"}, 32'(inverted_phase), 32'(s & 1));
    endtask

    task automatic check_rgb(input string name, input logic [23:0] exp);
        chk(name, {8'h0, red_out, green_out, blue_out}, {8'h0, exp});
    endtask

    initial begin
        int cur;
        int sweeps;

        vecs[0]  = '{0,  6'd5,  24'h0000FF};
        vecs[1]  = '{0,  6'd4,  24'hFF0000};
        vecs[2]  = '{0,  6'd49, 24'h0000FF};
        vecs[3]  = '{0,  6'd50, 24'h000000};
        vecs[4]  = '{0,  6'd63, 24'h000000};
        vecs[5]  = '{1,  6'd5,  24'hFF0000};
        vecs[6]  = '{1,  6'd4,  24'h0000FF};
        vecs[7]  = '{2,  6'd2,  24'h0000FF};
        vecs[8]  = '{2,  6'd5,  24'hFF0000};
        vecs[9]  = '{3,  6'd5,  24'h0000FF};
        vecs[10] = '{10, 6'd32, 24'h0000FF};
        vecs[11] = '{10, 6'd31, 24'hFF0000};
        vecs[12] = '{11, 6'd49, 24'hFF0000};
        vecs[13] = '{11, 6'd0,  24'h0000FF};

        // Reset with increment held high: no step change on release
        rst           = 1'b1;
        auto_mode     = 1'b0;
        increment_bit = 1'b1;
        decrement_bit = 1'b0;
        led_request   = '0;
        request_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_step("rst_step", 0);
        chk("rst_dfv", 32'(displayed_frame_valid), 32'd0);
        chk("rst_cv", 32'(color_valid), 32'd0);
        check_rgb("rst_rgb", 24'h0);
        chk("rst_sweep", 32'(sweep_done), 32'd0);
        tick();
        increment_bit = 1'b0;
        tick();
        tick();
        check_step("held_inc_step", 0);

        // Settle needs two frame starts
        req(6'd0);
        chk("settle_fs1_dfv", 32'(displayed_frame_valid), 32'd0);
        req(6'd0);
        chk("settle_fs2_dfv", 32'(displayed_frame_valid), 32'd1);

        // Out-of-range LED and one-cycle strobe
        req(6'd50);
        chk("oor_cv", 32'(color_valid), 32'd1);
        check_rgb("oor_rgb", 24'h000000);
        tick();
        chk("oor_cv_drop", 32'(color_valid), 32'd0);

        // Manual mode holds indefinitely
        for (int i = 0; i < 6; i++) req(6'd0);
        chk("manual_hold_dfv", 32'(displayed_frame_valid), 32'd1);
        check_step("manual_hold_step", 0);

        // Colour table
        cur = 0;
        for (int i = 0; i < 14; i++) begin
            while (cur != vecs[i].step) begin
                pulse_inc();
                cur = (cur + 1) % 12;
            end
            req(vecs[i].addr);
            check_rgb($sformatf("vec%0d_rgb", i), vecs[i].rgb);
            chk($sformatf("vec%0d_cv", i), 32'(color_valid), 32'd1);
            check_step($sformatf("vec%0d_step", i), vecs[i].step);
        end
        chk("inc_to_settle_dfv", 32'(displayed_frame_valid), 32'd0);

        // Wrap both directions
        pulse_inc();
        check_step("inc_wrap", 0);
        pulse_dec();
        check_step("dec_wrap", 11);

        // Simultaneous inc and dec: nothing changes
        req(6'd0);
        req(6'd0);
        chk("sim_pre_dfv", 32'(displayed_frame_valid), 32'd1);
        increment_bit = 1'b1;
        decrement_bit = 1'b1;
        tick();
        check_step("sim_step", 11);
        chk("sim_dfv", 32'(displayed_frame_valid), 32'd1);
        increment_bit = 1'b0;
        decrement_bit = 1'b0;
        tick();
        check_step("sim_rel_step", 11);

        // Manual edge beats an auto advance from the last step
        auto_mode = 1'b1;
        req(6'd0);
        req(6'd0);
        req(6'd0);
        check_step("pre_adv_step", 11);
        chk("pre_adv_dfv", 32'(displayed_frame_valid), 32'd1);
        led_request   = 6'd0;
        request_valid = 1'b1;
        increment_bit = 1'b1;
        tick();
        request_valid = 1'b0;
        check_step("race_step", 0);
        chk("race_sweep", 32'(sweep_done), 32'd0);
        chk("race_dfv", 32'(displayed_frame_valid), 32'd0);
        increment_bit = 1'b0;
        tick();
        chk("race_sweep2", 32'(sweep_done), 32'd0);
        req(6'd0);
        chk("race_fs1_dfv", 32'(displayed_frame_valid), 32'd0);
        req(6'd0);
        chk("race_fs2_dfv", 32'(displayed_frame_valid), 32'd1);

        // Full auto sweep from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        sweeps = 0;
        for (int s = 0; s < 12; s++) begin
            check_step($sformatf("auto%0d_step", s), s);
            req(6'd0);
            req(6'd0);
            chk($sformatf("auto%0d_dfv", s), 32'(displayed_frame_valid), 32'd1);
            for (int f = 0; f < 3; f++) req(6'd0);
            chk($sformatf("auto%0d_hold", s), 32'(displayed_frame_valid), 32'd1);
            check_step($sformatf("auto%0d_hstep", s), s);
            req(6'd0);
            if (sweep_done === 1'b1) sweeps++;
            chk($sformatf("auto%0d_sweep", s), 32'(sweep_done), (s == 11) ? 32'd1 : 32'd0);
            chk($sformatf("auto%0d_drop", s), 32'(displayed_frame_valid), 32'd0);
            check_step($sformatf("auto%0d_next", s), (s + 1) % 12);
            tick();
            chk($sformatf("auto%0d_sweep_pulse", s), 32'(sweep_done), 32'd0);
        end
        chk("sweep_count", 32'(sweeps), 32'd1);

        // Reset in HOLD with a request pending
        req(6'd0);
        req(6'd0);
        req(6'd5);
        chk("prerst_cv", 32'(color_valid), 32'd1);
        check_rgb("prerst_rgb", 24'h0000FF);
        led_request   = 6'd5;
        request_valid = 1'b1;
        rst           = 1'b1;
        #1;
        chk("midrst_cv", 32'(color_valid), 32'd0);
        check_rgb("midrst_rgb", 24'h0);
        chk("midrst_dfv", 32'(displayed_frame_valid), 32'd0);
        tick();
        chk("midrst_cv_edge", 32'(color_valid), 32'd0);
        check_rgb("midrst_rgb_edge", 24'h0);
        check_step("midrst_step", 0);
        rst           = 1'b0;
        request_valid = 1'b0;
        tick();
        chk("postrst_cv", 32'(color_valid), 32'd0);
        req(6'd0);
        chk("postrst_fs1_dfv", 32'(displayed_frame_valid), 32'd0);
        req(6'd0);
        chk("postrst_fs2_dfv", 32'(displayed_frame_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
